// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width limits for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // True when an operand width lies inside the supported range.
  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder cell
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor reusing one full adder over WIDTH cycles
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH must lie between MIN_WIDTH and MAX_WIDTH");
  end

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   s_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               cout_q;
  logic               ovf_q;
  logic               sum_bit;
  logic               cell_carry;
  logic               last_bit;
  logic               accept;

  // The single arithmetic cell, fed from the low ends of the operand shifters.
  full_adder u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (sum_bit),
    .Cout (cell_carry)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // A new request is taken in IDLE and in DONE (back-to-back), never mid-RUN.
  assign accept   = start && (state != RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: RUN lasts WIDTH cycles, DONE lasts one.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand load, LSB-first shifting, and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1, so the incoming carry is forced high.
      a_sr  <= A;
      b_sr  <= Sub ? ~B : B;
      carry <= Sub ? 1'b1 : Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      s_sr  <= {sum_bit, s_sr[WIDTH-1:1]};
      carry <= cell_carry;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        // carry still holds the carry into the MSB here.
        cout_q <= cell_carry;
        ovf_q  <= carry ^ cell_carry;
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign S        = s_sr;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule
